// File: rtl/rtc_mux_bus_master.sv
// rtc_mux_bus_master: sequences multiplexed address/data transactions to an
// external RTC. It performs burst reads of a register list into an atomic
// snapshot, or single register writes. It also runs periodic refresh bursts.
//
// state      | meaning
// IDLE       | bus released; accepts start or refresh
// ADDR_LATCH | address driven, ad high
// ADDR_WR    | address strobed with cs_n/wr_n low
// ADDR_END   | address held, strobes released
// TURN       | bus turnaround, nobody drives
// DATA_ACT   | read: rd_n low, capture on last cycle; write: wr_n low, data driven
// DATA_END   | cs_n held low, write data held
// GAP        | inter-transaction idle, GAP_CYC cycles
module rtc_mux_bus_master #(
    parameter int DW          = 8,
    parameter int N_REGS      = 10,
    parameter int PH          = 4,
    parameter int GAP_CYC     = 8,
    parameter int REFRESH_CYC = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [DW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [N_REGS*DW-1:0] addr_list,
    input  logic                 auto_en,
    output logic                 busy,
    output logic                 done,
    output logic [N_REGS*DW-1:0] rd_data,
    output logic                 rd_valid,
    input  logic [DW-1:0]        ad_in,
    output logic [DW-1:0]        ad_out,
    output logic                 ad_oe,
    output logic                 ad,
    output logic                 cs_n,
    output logic                 wr_n,
    output logic                 rd_n
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ADDR_LATCH = 3'd1;
    localparam logic [2:0] S_ADDR_WR    = 3'd2;
    localparam logic [2:0] S_ADDR_END   = 3'd3;
    localparam logic [2:0] S_TURN       = 3'd4;
    localparam logic [2:0] S_DATA_ACT   = 3'd5;
    localparam logic [2:0] S_DATA_END   = 3'd6;
    localparam logic [2:0] S_GAP        = 3'd7;

    localparam int TMAX = (PH > GAP_CYC) ? PH : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(REFRESH_CYC + 1);
    localparam int SW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    localparam logic [TW-1:0] PH_LD     = TW'(PH - 1);
    localparam logic [TW-1:0] GAP_LD    = TW'(GAP_CYC - 1);
    localparam logic [RW-1:0] REF_TC    = RW'(REFRESH_CYC - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_REGS - 1);

    logic [2:0]           r_state;
    logic [TW-1:0]        r_tmr;
    logic [RW-1:0]        r_rcnt;
    logic                 r_pend;
    logic                 r_op;
    logic [SW-1:0]        r_slot;
    logic [DW-1:0]        r_addr;
    logic [DW-1:0]        r_wdata;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_rd_valid;
    logic [N_REGS*DW-1:0] r_rd_data;
    logic [N_REGS*DW-1:0] r_shadow;

    logic                 w_tick;
    logic [SW-1:0]        w_nslot;
    logic [DW-1:0]        w_naddr;

    // Next slot index and its address from the register list
    always_comb begin
        w_tick  = auto_en && (r_rcnt == REF_TC);
        w_nslot = (r_state == S_IDLE) ? '0 : r_slot + 1'b1;
        w_naddr = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_nslot == SW'(i)) w_naddr = addr_list[i*DW +: DW];
        end
    end

    // Sequencer: phase timer, slot stepping, refresh counter and snapshot commit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_rcnt     <= '0;
            r_pend     <= 1'b0;
            r_op       <= 1'b0;
            r_slot     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    // a refresh due in the same cycle waits until this op ends
                    r_op    <= op;
                    r_addr  <= op ? wr_addr : w_naddr;
                    r_wdata <= wr_data;
                    r_slot  <= '0;
                    r_tmr   <= PH_LD;
                    r_state <= S_ADDR_LATCH;
                    r_busy  <= 1'b1;
                    r_pend  <= r_pend | w_tick;
                    r_rcnt  <= '0;
                end else if (w_tick || r_pend) begin
                    r_op    <= 1'b0;
                    r_addr  <= w_naddr;
                    r_slot  <= '0;
                    r_tmr   <= PH_LD;
                    r_state <= S_ADDR_LATCH;
                    r_busy  <= 1'b1;
                    r_pend  <= 1'b0;
                    r_rcnt  <= '0;
                end else if (auto_en) begin
                    r_rcnt <= r_rcnt + 1'b1;
                end else begin
                    r_rcnt <= '0;
                end
            end else if (r_tmr != '0) begin
                r_tmr <= r_tmr - 1'b1;
            end else begin
                r_tmr <= PH_LD;
                case (r_state)
                    S_ADDR_LATCH: r_state <= S_ADDR_WR;
                    S_ADDR_WR:    r_state <= S_ADDR_END;
                    S_ADDR_END:   r_state <= S_TURN;
                    S_TURN:       r_state <= S_DATA_ACT;
                    S_DATA_ACT:   r_state <= S_DATA_END;
                    S_DATA_END: begin
                        r_state <= S_GAP;
                        r_tmr   <= GAP_LD;
                    end
                    S_GAP: begin
                        if (r_op || (r_slot == LAST_SLOT)) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (!r_op) begin
                                r_rd_data  <= r_shadow;
                                r_rd_valid <= 1'b1;
                            end
                        end else begin
                            r_slot  <= w_nslot;
                            r_addr  <= w_naddr;
                            r_state <= S_ADDR_LATCH;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Shadow capture of ad_in on the last DATA_ACT cycle of each read
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= '0;
        end else if ((r_state == S_DATA_ACT) && (r_tmr == '0) && !r_op) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (r_slot == SW'(i)) r_shadow[i*DW +: DW] <= ad_in;
            end
        end
    end

    // Pin levels decoded from the current state
    always_comb begin
        ad     = !((r_state == S_ADDR_WR) || (r_state == S_ADDR_END));
        cs_n   = !((r_state == S_ADDR_WR) || (r_state == S_DATA_ACT) || (r_state == S_DATA_END));
        wr_n   = !((r_state == S_ADDR_WR) || ((r_state == S_DATA_ACT) && r_op));
        rd_n   = !((r_state == S_DATA_ACT) && !r_op);
        ad_oe  = 1'b0;
        ad_out = '0;
        if ((r_state == S_ADDR_LATCH) || (r_state == S_ADDR_WR) || (r_state == S_ADDR_END)) begin
            ad_oe  = 1'b1;
            ad_out = r_addr;
        end else if (r_op && ((r_state == S_DATA_ACT) || (r_state == S_DATA_END))) begin
            ad_oe  = 1'b1;
            ad_out = r_wdata;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_rtc_mux_bus_master.sv
// Testbench for rtc_mux_bus_master: two instances (default timing with a short
// refresh period, and a minimal PH=1/GAP=1 variant) against an RTC bus model
// that answers each read with address+0x10.
module tb_rtc_mux_bus_master;

    localparam int DW = 8;
    localparam int NA = 10, PHA = 4, GA = 8, RA = 50, TA = 6*PHA + GA;
    localparam int NB = 3,  PHB = 1, GB = 1, TB = 6*PHB + GB;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // instance A signals
    logic              a_reset = 1'b1, a_start = 1'b0, a_op = 1'b0, a_auto_en = 1'b0;
    logic [DW-1:0]     a_wr_addr = '0, a_wr_data = '0;
    logic [NA*DW-1:0]  a_addr_list = '0;
    logic              a_busy, a_done, a_rd_valid, a_ad_oe, a_ad, a_cs_n, a_wr_n, a_rd_n;
    logic [NA*DW-1:0]  a_rd_data;
    logic [DW-1:0]     a_ad_in = 8'hEE, a_ad_out;

    // instance B signals
    logic              b_reset = 1'b1, b_start = 1'b0, b_op = 1'b0, b_auto_en = 1'b0;
    logic [DW-1:0]     b_wr_addr = '0, b_wr_data = '0;
    logic [NB*DW-1:0]  b_addr_list = '0;
    logic              b_busy, b_done, b_rd_valid, b_ad_oe, b_ad, b_cs_n, b_wr_n, b_rd_n;
    logic [NB*DW-1:0]  b_rd_data;
    logic [DW-1:0]     b_ad_in = 8'hEE, b_ad_out;

    rtc_mux_bus_master #(.DW(DW), .N_REGS(NA), .PH(PHA), .GAP_CYC(GA), .REFRESH_CYC(RA)) dut_a (
        .clock(clock), .reset(a_reset), .start(a_start), .op(a_op),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data), .addr_list(a_addr_list),
        .auto_en(a_auto_en), .busy(a_busy), .done(a_done), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .ad_in(a_ad_in), .ad_out(a_ad_out), .ad_oe(a_ad_oe),
        .ad(a_ad), .cs_n(a_cs_n), .wr_n(a_wr_n), .rd_n(a_rd_n));

    rtc_mux_bus_master #(.DW(DW), .N_REGS(NB), .PH(PHB), .GAP_CYC(GB), .REFRESH_CYC(1000)) dut_b (
        .clock(clock), .reset(b_reset), .start(b_start), .op(b_op),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .addr_list(b_addr_list),
        .auto_en(b_auto_en), .busy(b_busy), .done(b_done), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .ad_in(b_ad_in), .ad_out(b_ad_out), .ad_oe(b_ad_oe),
        .ad(b_ad), .cs_n(b_cs_n), .wr_n(b_wr_n), .rd_n(b_rd_n));

    // RTC model A: remembers the latched address, returns valid data only in the
    // PH-th cycle of rd_n low, and logs address phases and write data.
    logic [DW-1:0] a_cur_addr = '0, a_last_wd = '0;
    logic          a_latch, a_prev_latch = 1'b0;
    logic [DW-1:0] a_addr_q[$];
    int            a_rdc = 0, a_addr_err = 0, a_rd_cycles = 0, a_wd_cycles = 0, a_wd_err = 0;

    always @(negedge clock) begin
        a_latch = a_ad && a_ad_oe && a_cs_n;
        if (a_latch) begin
            a_cur_addr = a_ad_out;
            if (!a_prev_latch) a_addr_q.push_back(a_ad_out);
        end
        a_prev_latch = a_latch;
        if (!a_ad && (!a_ad_oe || a_ad_out !== a_cur_addr)) a_addr_err++;
        if (!a_rd_n) begin
            a_rdc++;
            a_rd_cycles++;
        end else begin
            a_rdc = 0;
        end
        a_ad_in = (a_rdc == PHA) ? a_cur_addr + 8'h10 : 8'hEE;
        if (!a_wr_n && a_ad) begin
            a_wd_cycles++;
            a_last_wd = a_ad_out;
            if (!a_ad_oe) a_wd_err++;
        end
    end

    // RTC model B: same answer rule; counts write-data cycles
    logic [DW-1:0] b_cur_addr = '0;
    int            b_wd_cycles = 0;

    always @(negedge clock) begin
        if (b_ad && b_ad_oe && b_cs_n) b_cur_addr = b_ad_out;
        b_ad_in = !b_rd_n ? b_cur_addr + 8'h10 : 8'hEE;
        if (!b_wr_n && b_ad) b_wd_cycles++;
    end

    function automatic logic [NA*DW-1:0] model_a(input logic [NA*DW-1:0] list);
        logic [NA*DW-1:0] r;
        for (int i = 0; i < NA; i++) r[i*DW +: DW] = list[i*DW +: DW] + 8'h10;
        return r;
    endfunction

    function automatic logic [NA*DW-1:0] rand_list();
        logic [NA*DW-1:0] r;
        for (int i = 0; i < NA; i++) r[i*DW +: DW] = DW'($urandom_range(0, 8'hEF));
        return r;
    endfunction

    // Advances A one cycle at a time until done or cycle stop_at; cyc counts edges after acceptance
    task automatic a_wait(input int stop_at, inout int cyc);
        while (!(a_done === 1'b1) && cyc < stop_at) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic a_check_burst(input string tag, input logic [NA*DW-1:0] list,
                                 input int base, input int cyc, input int err0);
        int mism;
        logic [NA*DW-1:0] exp;
        exp = model_a(list);
        checks++;
        if (cyc !== NA*TA) $display("FAIL %s done_cycle got=%0d exp=%0d", tag, cyc, NA*TA);
        else passed++;
        checks++;
        if (a_rd_data !== exp) $display("FAIL %s rd_data got=%h exp=%h", tag, a_rd_data, exp);
        else passed++;
        checks++;
        if (a_busy !== 1'b0 || a_rd_valid !== 1'b1)
            $display("FAIL %s busy/rd_valid got=%b/%b exp=0/1", tag, a_busy, a_rd_valid);
        else passed++;
        mism = 0;
        for (int i = 0; i < NA; i++)
            if (base + i >= a_addr_q.size() || a_addr_q[base+i] !== list[i*DW +: DW]) mism++;
        checks++;
        if (mism != 0 || a_addr_err != err0)
            $display("FAIL %s addr_order mism=%0d addr_err=%0d exp=0/0", tag, mism, a_addr_err - err0);
        else passed++;
        @(negedge clock);
        checks++;
        if (a_done !== 1'b0) $display("FAIL %s done_width got=%b exp=0", tag, a_done);
        else passed++;
    endtask

    task automatic a_run_burst(input string tag, input logic [NA*DW-1:0] list,
                               input logic [NA*DW-1:0] prev);
        int base, cyc, err0;
        base = a_addr_q.size();
        err0 = a_addr_err;
        @(negedge clock);
        a_addr_list = list;
        a_op = 1'b0;
        a_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_start = 1'b0;
        checks++;
        if (a_busy !== 1'b1) $display("FAIL %s busy_at_start got=%b exp=1", tag, a_busy);
        else passed++;
        cyc = 0;
        a_wait(150, cyc);
        checks++;
        if (a_rd_data !== prev) $display("FAIL %s partial_rd_data got=%h exp=%h", tag, a_rd_data, prev);
        else passed++;
        a_wait(2000, cyc);
        a_check_burst(tag, list, base, cyc, err0);
    endtask

    task automatic a_run_write(input string tag, input logic [DW-1:0] wa, input logic [DW-1:0] wd,
                               input logic [NA*DW-1:0] prev);
        int base, cyc, rd0, wd0, err0, werr0;
        base = a_addr_q.size();
        rd0 = a_rd_cycles; wd0 = a_wd_cycles; err0 = a_addr_err; werr0 = a_wd_err;
        @(negedge clock);
        a_op = 1'b1; a_wr_addr = wa; a_wr_data = wd; a_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_start = 1'b0;
        a_wr_addr = ~wa; a_wr_data = ~wd;
        cyc = 0;
        a_wait(2000, cyc);
        checks++;
        if (cyc !== TA) $display("FAIL %s done_cycle got=%0d exp=%0d", tag, cyc, TA);
        else passed++;
        checks++;
        if (a_addr_q.size() != base + 1 || a_addr_q[base] !== wa || a_addr_err != err0)
            $display("FAIL %s address got=%h exp=%h addr_err=%0d", tag,
                     (a_addr_q.size() > base) ? a_addr_q[base] : 8'hXX, wa, a_addr_err - err0);
        else passed++;
        checks++;
        if (a_last_wd !== wd || a_wd_cycles - wd0 != PHA || a_wd_err != werr0)
            $display("FAIL %s wdata got=%h cycles=%0d exp=%h cycles=%0d", tag, a_last_wd,
                     a_wd_cycles - wd0, wd, PHA);
        else passed++;
        checks++;
        if (a_rd_cycles != rd0) $display("FAIL %s rd_n_low got=%0d exp=0", tag, a_rd_cycles - rd0);
        else passed++;
        checks++;
        if (a_rd_data !== prev || a_rd_valid !== 1'b1)
            $display("FAIL %s rd_data_kept got=%h exp=%h", tag, a_rd_data, prev);
        else passed++;
    endtask

    task automatic check_idle_pins(input string tag);
        checks++;
        if ({a_ad, a_cs_n, a_wr_n, a_rd_n, a_ad_oe} !== 5'b11110 || a_ad_out !== '0)
            $display("FAIL %s pins got=%b%b%b%b%b/%h exp=11110/00", tag, a_ad, a_cs_n, a_wr_n,
                     a_rd_n, a_ad_oe, a_ad_out);
        else passed++;
        checks++;
        if ({a_busy, a_done, a_rd_valid} !== 3'b000 || a_rd_data !== '0)
            $display("FAIL %s status got=%b%b%b/%h exp=000/0", tag, a_busy, a_done, a_rd_valid, a_rd_data);
        else passed++;
    endtask

    logic [NA*DW-1:0] list1;
    logic [NA*DW-1:0] last_rd;

    task automatic test_reset();
        a_reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle_pins("reset");
        a_reset = 1'b0;
    endtask

    task automatic test_burst();
        a_run_burst("burst_list", list1, '0);
        checks++;
        if (a_rd_data[7:0] !== 8'h36 || a_rd_data[9*DW +: DW] !== 8'h11)
            $display("FAIL burst_slots got=%h/%h exp=36/11", a_rd_data[7:0], a_rd_data[9*DW +: DW]);
        else passed++;
        last_rd = model_a(list1);
        for (int k = 0; k < 2; k++) begin
            logic [NA*DW-1:0] l;
            l = rand_list();
            a_run_burst("burst_rand", l, last_rd);
            last_rd = model_a(l);
        end
    endtask

    task automatic test_write();
        a_run_write("write_fixed", 8'h22, 8'h59, last_rd);
        for (int k = 0; k < 2; k++)
            a_run_write("write_rand", DW'($urandom), DW'($urandom), last_rd);
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clock);
        a_addr_list = list1; a_op = 1'b0; a_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_start = 1'b0;
        cyc = 0;
        a_wait(150, cyc);
        a_reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_idle_pins("reset_mid");
        a_reset = 1'b0;
        a_run_burst("after_reset", list1, '0);
    endtask

    task automatic test_refresh();
        int n, cyc, base, err0;
        logic [NA*DW-1:0] l;
        l = rand_list();
        a_reset = 1'b1; a_auto_en = 1'b1; a_addr_list = l;
        repeat (2) @(posedge clock);
        @(negedge clock);
        a_reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            base = a_addr_q.size();
            err0 = a_addr_err;
            n = 0;
            while (a_busy !== 1'b1 && n < 500) begin
                @(posedge clock);
                n++;
                @(negedge clock);
            end
            checks++;
            if (n != RA) $display("FAIL refresh_interval%0d got=%0d exp=%0d", k, n, RA);
            else passed++;
            if (k == 1) a_auto_en = 1'b0;
            cyc = 0;
            a_wait(2000, cyc);
            a_check_burst("refresh_burst", l, base, cyc, err0);
            // a_check_burst consumed the done cycle; back up to measure from done
            if (k == 0) begin
                n = 1;
                while (a_busy !== 1'b1 && n < 500) begin
                    @(posedge clock);
                    n++;
                    @(negedge clock);
                end
                checks++;
                if (n != RA) $display("FAIL refresh_after_done got=%0d exp=%0d", n, RA);
                else passed++;
                cyc = 0;
                a_wait(2000, cyc);
                a_check_burst("refresh_burst2", l, base, cyc, err0);
                a_auto_en = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_tick_vs_start();
        int cyc, base, err0;
        logic [NA*DW-1:0] l;
        l = rand_list();
        a_reset = 1'b1; a_auto_en = 1'b1; a_addr_list = l;
        repeat (2) @(posedge clock);
        @(negedge clock);
        a_reset = 1'b0;
        repeat (RA - 1) @(posedge clock);
        @(negedge clock);
        base = a_addr_q.size();
        err0 = a_addr_err;
        a_op = 1'b1; a_wr_addr = 8'h3C; a_wr_data = 8'hA5; a_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_start = 1'b0;
        a_op = 1'b0;
        cyc = 0;
        a_wait(2000, cyc);
        checks++;
        if (cyc != TA || a_busy !== 1'b0) $display("FAIL tick_write_done got=%0d exp=%0d", cyc, TA);
        else passed++;
        checks++;
        if (a_addr_q.size() <= base || a_addr_q[base] !== 8'h3C || a_last_wd !== 8'hA5)
            $display("FAIL tick_write_first got=%h/%h exp=3c/a5",
                     (a_addr_q.size() > base) ? a_addr_q[base] : 8'hXX, a_last_wd);
        else passed++;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (a_busy !== 1'b1) $display("FAIL tick_pending_start got=%b exp=1", a_busy);
        else passed++;
        a_auto_en = 1'b0;
        cyc = 0;
        a_wait(2000, cyc);
        a_check_burst("tick_burst", l, base + 1, cyc, err0);
    endtask

    task automatic test_busy_ignore();
        int cyc, rd_err, wd0, idle_err;
        logic [NB*DW-1:0] l, exp;
        for (int i = 0; i < NB; i++) l[i*DW +: DW] = DW'($urandom_range(0, 8'hEF));
        for (int i = 0; i < NB; i++) exp[i*DW +: DW] = l[i*DW +: DW] + 8'h10;
        @(negedge clock);
        b_reset = 1'b0;
        b_addr_list = l;
        b_op = 1'b0;
        b_start = 1'b1;
        wd0 = b_wd_cycles;
        @(posedge clock);
        @(negedge clock);
        cyc = 0;
        rd_err = 0;
        while (1) begin
            if ((b_rd_n === 1'b0) != ((cyc % TB) == 4 && cyc < NB*TB)) rd_err++;
            b_start = (cyc == 3 || cyc == 9 || cyc == 15);
            b_op = 1'b1;
            b_wr_addr = 8'h5A;
            if (b_done === 1'b1 || cyc >= 500) break;
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        b_start = 1'b0;
        checks++;
        if (cyc != NB*TB) $display("FAIL ph1_done_cycle got=%0d exp=%0d", cyc, NB*TB);
        else passed++;
        checks++;
        if (rd_err != 0) $display("FAIL ph1_sample_timing got=%0d exp=0", rd_err);
        else passed++;
        checks++;
        if (b_rd_data !== exp || b_rd_valid !== 1'b1)
            $display("FAIL ph1_rd_data got=%h exp=%h", b_rd_data, exp);
        else passed++;
        idle_err = 0;
        repeat (6) begin
            @(negedge clock);
            if (b_busy !== 1'b0) idle_err++;
        end
        checks++;
        if (idle_err != 0 || b_wd_cycles != wd0)
            $display("FAIL busy_start_ignored got=%0d/%0d exp=0/0", idle_err, b_wd_cycles - wd0);
        else passed++;
    endtask

    initial begin
        list1 = {8'h01, 8'h08, 8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        last_rd = '0;
        test_reset();
        test_burst();
        test_write();
        test_reset_mid();
        test_refresh();
        test_tick_vs_start();
        test_busy_ignore();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
